mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Parametrised multicycle main control unit for the MIPS datapath, replacing the fixed-latency decoder. It adds a ready/request handshake on every memory access, a variable-latency FPU start/done handshake with a timeout, and an illegal-opcode trap state. It sits between the instruction register opcode field and the datapath mux/enable controls, and still emits the ALU-decoder aluop.

Parameters:
OP_W, 6, opcode field width
ALUOP_W, 3, aluop width sent to the ALU decoder
FP_TIMEOUT, 16, maximum FPWAIT cycles before trap (>=1)
TRAP_PCSRC, 2'b11, pcsrc code that selects the exception vector

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
op  in  OP_W  instruction opcode
mem_ready  in  1  memory completed the current access this cycle
fpu_done  in  1  FPU result valid, one-cycle pulse
pcwrite, memwrite, irwrite, regwrite_int, regwrite_float  out  1 each  datapath write enables
alusrca, branch, iord, memtoreg, regdst  out  1 each  datapath mux/branch controls
alusrcb  out  2  ALU B select
pcsrc  out  2  next-PC select
aluop  out  ALUOP_W  ALU decoder op
mem_req  out  1  memory access in progress
fpu_start  out  1  one-cycle FPU launch pulse
illegal_op  out  1  trap indication, one cycle
epc_write  out  1  capture the faulting PC
state_o  out  5  current state, for debug and the bench

Behaviour:
- Outputs are Moore, decoded from the registered state, except the mem_ready-qualified enables noted below.
- While reset=0: state=FETCH, the FP counter is 0, and every write enable, mem_req, fpu_start, illegal_op and epc_write is forced to 0. Reset asserted mid-instruction aborts it with no partial write.
- Opcodes: LW=100011, SW=101011, RTYPE=000000, BEQ=000100, BNE=000101, ADDI=001000, SLTI=001010, ANDI=001100, ORI=001101, J=000010, FLOAT=010001.
- aluop codes: add=000, sub(beq)=001, funct=010, sub(bne)=011, or=100, and=101, slt=111.
- FETCH: mem_req=1, alusrcb=01. irwrite and pcwrite assert only in the cycle mem_ready=1, which also moves to DECODE. Otherwise FETCH holds.
- DECODE: alusrcb=11. Next state by opcode: LW/SW->MEMADR, RTYPE->RTYPEEX, BEQ->BEQEX, BNE->BNEEX, ADDI/ORI/ANDI/SLTI->IMMEX, J->JEX, FLOAT->FPEX, any other opcode->TRAP.
- MEMADR: alusrca=1, alusrcb=10. LW->MEMRD, SW->MEMWR.
- MEMRD: iord=1, mem_req=1. Holds until mem_ready, then ->MEMWB.
- MEMWB: regwrite_int=1, memtoreg=1. ->FETCH.
- MEMWR: iord=1, mem_req=1, memwrite=1 (level). Holds until mem_ready, then ->FETCH.
- RTYPEEX: alusrca=1, aluop=funct. ->RTYPEWB.
- RTYPEWB: regwrite_int=1, regdst=1. ->FETCH.
- BEQEX/BNEEX: alusrca=1, branch=1, pcsrc=01, aluop=001 or 011. ->FETCH.
- IMMEX: alusrca=1, alusrcb=10. aluop from opcode: ADDI add, ORI or, ANDI and, SLTI slt. The opcode is latched in DECODE and used here. ->IMMWB.
- IMMWB: regwrite_int=1. ->FETCH.
- JEX: pcwrite=1, pcsrc=10. ->FETCH.
- FPEX: fpu_start=1 for exactly one cycle, counter cleared. ->FPWAIT.
- FPWAIT: counter increments each cycle.
  - fpu_done=1 ->FPWB, and the counter is ignored.
  - Counter reaches FP_TIMEOUT with no done ->TRAP.
  - If fpu_done arrives in the same cycle the timeout would fire, done wins.
- FPWB: regwrite_float=1, regdst=1. ->FETCH.
- TRAP: illegal_op=1, epc_write=1, pcwrite=1, pcsrc=TRAP_PCSRC. ->FETCH.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored. fpu_done outside FPWAIT is ignored.
- Unreachable encodings ->FETCH with all enables 0. Never x.

Optional Feature:
MC_CTRL_FLOAT_EN
- Defined: FPEX/FPWAIT/FPWB exist, and the FP counter plus fpu_start/regwrite_float are live.
- Undefined: FLOAT decodes to TRAP. fpu_start and regwrite_float are tied to 0 and the counter is not built.

Decomposition:
- Package mc_ctrl_pkg holds the opcode localparams, aluop codes, the state enum (5-bit encoding) and the control-word field positions.
- One sub-module, mc_ctrl_outdec: combinational state -> control-word decoder.
- The FSM, the FP counter and the opcode latch stay in mc_ctrl_fsm.

Test Plan:
- LW with mem_ready=0 for 3 cycles in both FETCH and MEMRD -> states hold, irwrite/pcwrite pulse once, regwrite_int=1 and memtoreg=1 in MEMWB, 11 cycles total.
- SW with mem_ready delayed 2 cycles -> memwrite=1 and iord=1 for 3 cycles, then FETCH; regwrite_int never asserts.
- ORI then SLTI back-to-back -> aluop=100 then 111 in IMMEX, regwrite_int in IMMWB; BNE -> aluop=011, branch=1.
- FLOAT with fpu_done after 5 cycles -> one fpu_start pulse, regwrite_float=1 in FPWB. With fpu_done withheld (FP_TIMEOUT=16) -> TRAP, illegal_op=1, pcsrc=11. fpu_done on the timeout cycle -> FPWB.
- Opcode 111111 -> DECODE->TRAP->FETCH, epc_write one cycle. With MC_CTRL_FLOAT_EN undefined, op=010001 also traps.
- reset=0 asserted during MEMWR and FPWAIT -> immediate FETCH, all enables 0. Release -> normal fetch resumes.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control unit:
// opcodes, aluop codes, state encoding and the control-word layout.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_FLOAT = 6'b010001;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB_EQ = 3'b001;
    localparam logic [2:0] ALU_FUNCT  = 3'b010;
    localparam logic [2:0] ALU_SUB_NE = 3'b011;
    localparam logic [2:0] ALU_OR     = 3'b100;
    localparam logic [2:0] ALU_AND    = 3'b101;
    localparam logic [2:0] ALU_SLT    = 3'b111;

    typedef enum logic [4:0] {
        FETCH   = 5'd0,
        DECODE  = 5'd1,
        MEMADR  = 5'd2,
        MEMRD   = 5'd3,
        MEMWB   = 5'd4,
        MEMWR   = 5'd5,
        RTYPEEX = 5'd6,
        RTYPEWB = 5'd7,
        BEQEX   = 5'd8,
        BNEEX   = 5'd9,
        IMMEX   = 5'd10,
        IMMWB   = 5'd11,
        JEX     = 5'd12,
        FPEX    = 5'd13,
        FPWAIT  = 5'd14,
        FPWB    = 5'd15,
        TRAP    = 5'd16
    } state_e;

    // Control word; field order fixes the bit positions (MSB first).
    typedef struct packed {
        logic       pcwrite;
        logic       memwrite;
        logic       regwrite_int;
        logic       regwrite_float;
        logic       alusrca;
        logic       branch;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       mem_req;
        logic       fpu_start;
        logic       illegal_op;
        logic       epc_write;
    } ctrl_t;

    localparam int CW_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Memory and FPU handshake bundle of the main control unit.
// master: controller (drives mem_req/fpu_start); slave: memory/FPU side.
interface mc_ctrl_fsm_if;
    logic mem_req;
    logic mem_ready;
    logic fpu_start;
    logic fpu_done;

    modport master (
        output mem_req,
        output fpu_start,
        input  mem_ready,
        input  fpu_done
    );

    modport slave (
        input  mem_req,
        input  fpu_start,
        output mem_ready,
        output fpu_done
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Moore decoder: registered state (+ latched imm aluop) -> control word.
// Ports: state, imm_aluop in; cw (ctrl_t) out. Unknown states give all zeros.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
#(
    parameter logic [1:0] TRAP_PCSRC = 2'b11
) (
    input  state_e     state,
    input  logic [2:0] imm_aluop,
    output ctrl_t      cw
);

    always_comb begin
        cw = '0;
        case (state)
            FETCH: begin
                cw.mem_req = 1'b1;
                cw.alusrcb = 2'b01;
            end
            DECODE:  cw.alusrcb = 2'b11;
            MEMADR: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = 2'b10;
            end
            MEMRD: begin
                cw.iord    = 1'b1;
                cw.mem_req = 1'b1;
            end
            MEMWB: begin
                cw.regwrite_int = 1'b1;
                cw.memtoreg     = 1'b1;
            end
            MEMWR: begin
                cw.iord     = 1'b1;
                cw.mem_req  = 1'b1;
                cw.memwrite = 1'b1;
            end
            RTYPEEX: begin
                cw.alusrca = 1'b1;
                cw.aluop   = ALU_FUNCT;
            end
            RTYPEWB: begin
                cw.regwrite_int = 1'b1;
                cw.regdst       = 1'b1;
            end
            BEQEX, BNEEX: begin
                cw.alusrca = 1'b1;
                cw.branch  = 1'b1;
                cw.pcsrc   = 2'b01;
                cw.aluop   = (state == BEQEX) ? ALU_SUB_EQ : ALU_SUB_NE;
            end
            IMMEX: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = 2'b10;
                cw.aluop   = imm_aluop;
            end
            IMMWB:   cw.regwrite_int = 1'b1;
            JEX: begin
                cw.pcwrite = 1'b1;
                cw.pcsrc   = 2'b10;
            end
            FPEX:    cw.fpu_start = 1'b1;
            FPWB: begin
                cw.regwrite_float = 1'b1;
                cw.regdst         = 1'b1;
            end
            TRAP: begin
                cw.illegal_op = 1'b1;
                cw.epc_write  = 1'b1;
                cw.pcwrite    = 1'b1;
                cw.pcsrc      = TRAP_PCSRC;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control FSM with memory/FPU handshakes and trap.
// Ports: clk, reset (async active-low), op, bus (mc_ctrl_fsm_if.master),
// datapath enables/mux controls, aluop, illegal_op, epc_write, state_o.
// MC_CTRL_FLOAT_EN builds the FPEX/FPWAIT/FPWB path and its timeout counter.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int         OP_W       = 6,
    parameter int         ALUOP_W    = 3,
    parameter int         FP_TIMEOUT = 16,
    parameter logic [1:0] TRAP_PCSRC = 2'b11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    mc_ctrl_fsm_if.master      bus,
    output logic               pcwrite,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite_int,
    output logic               regwrite_float,
    output logic               alusrca,
    output logic               branch,
    output logic               iord,
    output logic               memtoreg,
    output logic               regdst,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [ALUOP_W-1:0] aluop,
    output logic               illegal_op,
    output logic               epc_write,
    output logic [4:0]         state_o
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [2:0]        imm_aluop;
    ctrl_t             cw;
    logic              fetch_ack;

`ifdef MC_CTRL_FLOAT_EN
    localparam int CNT_W = $clog2(FP_TIMEOUT + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            op_q    <= '0;
`ifdef MC_CTRL_FLOAT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
`ifdef MC_CTRL_FLOAT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
`ifdef MC_CTRL_FLOAT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            FETCH: if (bus.mem_ready) state_d = DECODE;
            DECODE: begin
                op_d = op;
                case (op)
                    OP_W'(OP_LW), OP_W'(OP_SW): state_d = MEMADR;
                    OP_W'(OP_RTYPE): state_d = RTYPEEX;
                    OP_W'(OP_BEQ):   state_d = BEQEX;
                    OP_W'(OP_BNE):   state_d = BNEEX;
                    OP_W'(OP_ADDI), OP_W'(OP_ORI),
                    OP_W'(OP_ANDI), OP_W'(OP_SLTI): state_d = IMMEX;
                    OP_W'(OP_J):     state_d = JEX;
`ifdef MC_CTRL_FLOAT_EN
                    OP_W'(OP_FLOAT): state_d = FPEX;
`endif
                    default:         state_d = TRAP;
                endcase
            end
            MEMADR: begin
                if (op_q == OP_W'(OP_LW)) state_d = MEMRD;
                else                      state_d = MEMWR;
            end
            MEMRD:   if (bus.mem_ready) state_d = MEMWB;
            MEMWR:   if (bus.mem_ready) state_d = FETCH;
            RTYPEEX: state_d = RTYPEWB;
            IMMEX:   state_d = IMMWB;
            MEMWB, RTYPEWB, BEQEX, BNEEX,
            IMMWB, JEX, TRAP: state_d = FETCH;
`ifdef MC_CTRL_FLOAT_EN
            FPEX: begin
                cnt_d   = '0;
                state_d = FPWAIT;
            end
            FPWAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // done takes priority over a timeout in the same cycle
                if (bus.fpu_done)
                    state_d = FPWB;
                else if (cnt_q == CNT_W'(FP_TIMEOUT - 1))
                    state_d = TRAP;
            end
            FPWB:    state_d = FETCH;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Immediate-op aluop comes from the opcode captured in DECODE
    always_comb begin
        imm_aluop = ALU_ADD;
        case (op_q)
            OP_W'(OP_ORI):  imm_aluop = ALU_OR;
            OP_W'(OP_ANDI): imm_aluop = ALU_AND;
            OP_W'(OP_SLTI): imm_aluop = ALU_SLT;
            default:        imm_aluop = ALU_ADD;
        endcase
    end

    mc_ctrl_outdec #(
        .TRAP_PCSRC (TRAP_PCSRC)
    ) u_outdec (
        .state     (state_q),
        .imm_aluop (imm_aluop),
        .cw        (cw)
    );

    assign fetch_ack = (state_q == FETCH) && bus.mem_ready;

    // Enables and requests are gated by reset so nothing fires while held
    always_comb begin
        pcwrite       = reset & (cw.pcwrite | fetch_ack);
        irwrite       = reset & fetch_ack;
        memwrite      = reset & cw.memwrite;
        regwrite_int  = reset & cw.regwrite_int;
        illegal_op    = reset & cw.illegal_op;
        epc_write     = reset & cw.epc_write;
        bus.mem_req   = reset & cw.mem_req;
`ifdef MC_CTRL_FLOAT_EN
        regwrite_float = reset & cw.regwrite_float;
        bus.fpu_start  = reset & cw.fpu_start;
`else
        regwrite_float = 1'b0;
        bus.fpu_start  = 1'b0;
`endif
        alusrca  = cw.alusrca;
        branch   = cw.branch;
        iord     = cw.iord;
        memtoreg = cw.memtoreg;
        regdst   = cw.regdst;
        alusrcb  = cw.alusrcb;
        pcsrc    = cw.pcsrc;
        aluop    = ALUOP_W'(cw.aluop);
        state_o  = state_q;
    end

`ifndef MC_CTRL_FLOAT_EN
    logic unused_fp;
    assign unused_fp = ^{cw.regwrite_float, cw.fpu_start, bus.fpu_done};
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm.
// Honours MC_CTRL_FLOAT_EN to pick the FLOAT scenarios.
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BNE   = 6'b000101;
    localparam logic [5:0] T_SLTI  = 6'b001010;
    localparam logic [5:0] T_ORI   = 6'b001101;
    localparam logic [5:0] T_FLOAT = 6'b010001;
    localparam logic [5:0] T_BAD   = 6'b111111;

    // en_w = {pcwrite, memwrite, irwrite, regwrite_int, regwrite_float,
    //         mem_req, fpu_start, illegal_op, epc_write}
    localparam logic [8:0] EN_NONE = 9'b000000000;
    localparam logic [8:0] EN_MREQ = 9'b000001000;
    localparam logic [8:0] EN_FACK = 9'b101001000;
    localparam logic [8:0] EN_MWR  = 9'b010001000;
    localparam logic [8:0] EN_RWI  = 9'b000100000;
    localparam logic [8:0] EN_RWF  = 9'b000010000;
    localparam logic [8:0] EN_FST  = 9'b000000100;
    localparam logic [8:0] EN_TRAP = 9'b100000011;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       pcwrite, memwrite, irwrite, regwrite_int, regwrite_float;
    logic       alusrca, branch, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluop;
    logic       illegal_op, epc_write;
    logic [4:0] state_o;
    logic [8:0] en_w;

    int n_cmp = 0;
    int n_bad = 0;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm dut (
        .clk            (clk),
        .reset          (reset),
        .op             (op),
        .bus            (bus),
        .pcwrite        (pcwrite),
        .memwrite       (memwrite),
        .irwrite        (irwrite),
        .regwrite_int   (regwrite_int),
        .regwrite_float (regwrite_float),
        .alusrca        (alusrca),
        .branch         (branch),
        .iord           (iord),
        .memtoreg       (memtoreg),
        .regdst         (regdst),
        .alusrcb        (alusrcb),
        .pcsrc          (pcsrc),
        .aluop          (aluop),
        .illegal_op     (illegal_op),
        .epc_write      (epc_write),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    assign en_w = {pcwrite, memwrite, irwrite, regwrite_int,
                   regwrite_float, bus.mem_req, bus.fpu_start,
                   illegal_op, epc_write};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic at(input string tag, input state_e st,
                      input logic [8:0] en);
        #1;
        chk({tag, "_st"}, 32'(state_o), 32'(st));
        chk({tag, "_en"}, 32'(en_w), 32'(en));
    endtask

    // FETCH with `waits` stalled cycles, then DECODE
    task automatic fetch(input logic [5:0] o, input int waits);
        op = o;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < waits; i++) begin
            at("fetch_wait", FETCH, EN_MREQ);
            tick();
        end
        bus.mem_ready = 1'b1;
        at("fetch_ack", FETCH, EN_FACK);
        chk("fetch_srcb", 32'(alusrcb), 32'd1);
        tick();
        bus.mem_ready = 1'b0;
        at("decode", DECODE, EN_NONE);
        chk("decode_srcb", 32'(alusrcb), 32'd3);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        op = '0;
        bus.mem_ready = 1'b0;
        bus.fpu_done = 1'b0;
        tick();
        tick();
        bus.mem_ready = 1'b1;
        at("rst", FETCH, EN_NONE);
        reset = 1'b1;
        bus.mem_ready = 1'b0;

        // LW: 3 stalls in FETCH and MEMRD, 11 cycles total
        fetch(T_LW, 3);
        at("lw_adr", MEMADR, EN_NONE);
        chk("lw_adr_mux", 32'({alusrca, alusrcb}), 32'b110);
        tick();
        for (int i = 0; i < 3; i++) begin
            at("lw_rd_wait", MEMRD, EN_MREQ);
            chk("lw_rd_iord", 32'(iord), 32'd1);
            tick();
        end
        bus.mem_ready = 1'b1;
        at("lw_rd_ack", MEMRD, EN_MREQ);
        tick();
        bus.mem_ready = 1'b0;
        at("lw_wb", MEMWB, EN_RWI);
        chk("lw_wb_m2r", 32'(memtoreg), 32'd1);
        tick();
        at("lw_done", FETCH, EN_MREQ);

        // SW: ready after 2 cycles -> 3 cycles of memwrite
        fetch(T_SW, 0);
        at("sw_adr", MEMADR, EN_NONE);
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = (i == 2);
            at("sw_wr", MEMWR, EN_MWR);
            chk("sw_wr_iord", 32'(iord), 32'd1);
            tick();
        end
        bus.mem_ready = 1'b0;
        at("sw_done", FETCH, EN_MREQ);

        // ORI, opcode changes after DECODE must not matter
        fetch(T_ORI, 0);
        op = T_BAD;
        at("ori_ex", IMMEX, EN_NONE);
        chk("ori_aluop", 32'(aluop), 32'b100);
        tick();
        at("ori_wb", IMMWB, EN_RWI);
        tick();

        fetch(T_SLTI, 0);
        at("slti_ex", IMMEX, EN_NONE);
        chk("slti_aluop", 32'(aluop), 32'b111);
        tick();
        at("slti_wb", IMMWB, EN_RWI);
        tick();

        fetch(T_BNE, 0);
        at("bne_ex", BNEEX, EN_NONE);
        chk("bne_aluop", 32'(aluop), 32'b011);
        chk("bne_br", 32'({branch, pcsrc}), 32'b101);
        tick();
        at("bne_done", FETCH, EN_MREQ);

        // Illegal opcode
        fetch(T_BAD, 0);
        at("ill_trap", TRAP, EN_TRAP);
        chk("ill_pcsrc", 32'(pcsrc), 32'b11);
        tick();
        at("ill_done", FETCH, EN_MREQ);

`ifdef MC_CTRL_FLOAT_EN
        // FLOAT, done in the 5th wait cycle
        fetch(T_FLOAT, 0);
        at("fp_ex", FPEX, EN_FST);
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.fpu_done = (i == 4);
            at("fp_wait", FPWAIT, EN_NONE);
            tick();
        end
        bus.fpu_done = 1'b0;
        at("fp_wb", FPWB, EN_RWF);
        chk("fp_wb_dst", 32'(regdst), 32'd1);
        tick();

        // no done: 16 wait cycles then TRAP
        fetch(T_FLOAT, 0);
        at("fpto_ex", FPEX, EN_FST);
        tick();
        for (int i = 0; i < 16; i++) begin
            at("fpto_wait", FPWAIT, EN_NONE);
            tick();
        end
        at("fpto_trap", TRAP, EN_TRAP);
        chk("fpto_pcsrc", 32'(pcsrc), 32'b11);
        tick();

        // done on the timeout cycle wins
        fetch(T_FLOAT, 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            bus.fpu_done = (i == 15);
            at("fpedge_wait", FPWAIT, EN_NONE);
            tick();
        end
        bus.fpu_done = 1'b0;
        at("fpedge_wb", FPWB, EN_RWF);
        tick();

        // reset during FPWAIT
        fetch(T_FLOAT, 0);
        tick();
        tick();
        reset = 1'b0;
        at("fprst", FETCH, EN_NONE);
        tick();
        reset = 1'b1;
`else
        fetch(T_FLOAT, 0);
        at("fpdis_trap", TRAP, EN_TRAP);
        tick();
        at("fpdis_done", FETCH, EN_MREQ);
`endif

        // reset during MEMWR
        fetch(T_SW, 0);
        tick();
        at("swrst_wr", MEMWR, EN_MWR);
        reset = 1'b0;
        at("swrst", FETCH, EN_NONE);
        tick();
        at("swrst_hold", FETCH, EN_NONE);
        reset = 1'b1;
        fetch(T_LW, 1);
        at("resume_adr", MEMADR, EN_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
